// File: rtl/alu_cmd_issuer_pkg.sv
// Shared types for the ALU command issuer: command record, FSM states and
// the error code reported when the optional watchdog fires.
package alu_cmd_issuer_pkg;

  // One queued ALU command, 74 bits
  typedef struct packed {
    logic [31:0] a;
    logic [31:0] b;
    logic        sv;
    logic        op_prefix;
    logic [7:0]  op;
  } alu_cmd_t;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    RESP  = 2'd2
  } issuer_state_t;

  localparam logic [7:0] ERR_TIMEOUT = 8'hFF;

endpackage

// File: rtl/alu_cmd_fifo.sv
// Small command FIFO. The head entry is visible on dout whenever the FIFO is
// non-empty, so the consumer can load it in the same cycle it pops.
// DEPTH must be a power of two so the pointers wrap naturally.
module alu_cmd_fifo
  import alu_cmd_issuer_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic                   clk,
  input  logic                   reset_n,
  input  logic                   push,
  input  alu_cmd_t               din,
  input  logic                   pop,
  output alu_cmd_t               dout,
  output logic                   full,
  output logic                   empty,
  output logic [$clog2(DEPTH):0] count
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  alu_cmd_t        mem_q [DEPTH];
  logic [AW-1:0]   wr_ptr_q;
  logic [AW-1:0]   rd_ptr_q;
  logic [CW-1:0]   count_q;
  logic [CW-1:0]   count_d;
  logic            push_ok;
  logic            pop_ok;

  assign full    = (count_q == CW'(DEPTH));
  assign empty   = (count_q == '0);
  assign count   = count_q;
  assign dout    = mem_q[rd_ptr_q];
  assign push_ok = push && !full;
  assign pop_ok  = pop && !empty;

  // Occupancy: simultaneous push and pop leave it unchanged
  always_comb begin
    count_d = count_q;
    unique case ({push_ok, pop_ok})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
  end

  // Pointer and occupancy registers
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (push_ok) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (pop_ok)  rd_ptr_q <= rd_ptr_q + 1'b1;
      count_q <= count_d;
    end
  end

  // Entry storage; no reset needed since empty masks stale contents
  always_ff @(posedge clk) begin
    if (push_ok) mem_q[wr_ptr_q] <= din;
  end

endmodule

// File: rtl/alu_cmd_issuer.sv
// Command-side front end for the tiny ALU: buffers commands, issues them one
// at a time with start held until done, and returns the ALU response on a
// valid/ready channel.
// Optional macro ISSUER_TIMEOUT_EN adds a watchdog (TIMEOUT_CYCLES parameter
// and sticky timeout_seen output) that aborts a command the ALU never answers.
module alu_cmd_issuer
  import alu_cmd_issuer_pkg::*;
#(
  parameter int DEPTH = 4
`ifdef ISSUER_TIMEOUT_EN
  , parameter int TIMEOUT_CYCLES = 64
`endif
) (
  input  logic                   clk,
  input  logic                   reset_n,
  input  logic                   cmd_valid,
  output logic                   cmd_ready,
  input  logic [31:0]            cmd_a,
  input  logic [31:0]            cmd_b,
  input  logic                   cmd_sv,
  input  logic                   cmd_op_prefix,
  input  logic [7:0]             cmd_op,
  output logic                   start,
  output logic [7:0]             op,
  output logic [31:0]            A,
  output logic [31:0]            B,
  output logic                   sv,
  output logic                   op_prefix,
  input  logic                   done,
  input  logic [63:0]            result,
  input  logic [7:0]             err,
  input  logic                   gp,
  output logic                   rsp_valid,
  input  logic                   rsp_ready,
  output logic [63:0]            rsp_result,
  output logic [7:0]             rsp_err,
  output logic                   rsp_gp,
  output logic                   busy,
  output logic [$clog2(DEPTH):0] count
`ifdef ISSUER_TIMEOUT_EN
  , output logic                 timeout_seen
`endif
);

  issuer_state_t state_q;
  logic          start_q;
  logic [7:0]    op_q;
  logic [31:0]   a_q;
  logic [31:0]   b_q;
  logic          sv_q;
  logic          op_prefix_q;
  logic          rsp_valid_q;
  logic [63:0]   rsp_result_q;
  logic [7:0]    rsp_err_q;
  logic          rsp_gp_q;

  alu_cmd_t      fifo_din;
  alu_cmd_t      fifo_dout;
  logic          fifo_full;
  logic          fifo_empty;
  logic          fifo_push;
  logic          fifo_pop;

`ifdef ISSUER_TIMEOUT_EN
  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
  logic [TW-1:0] timer_q;
  logic          timeout_seen_q;
  assign timeout_seen = timeout_seen_q;
`endif

  // cmd_ready looks only at occupancy and is forced low while in reset
  assign cmd_ready = reset_n && !fifo_full;
  assign fifo_push = cmd_valid && cmd_ready;
  assign fifo_pop  = (state_q == IDLE) && !fifo_empty;
  assign busy      = (state_q != IDLE) || !fifo_empty;

  // Pack the incoming command for the FIFO
  always_comb begin
    fifo_din           = '0;
    fifo_din.a         = cmd_a;
    fifo_din.b         = cmd_b;
    fifo_din.sv        = cmd_sv;
    fifo_din.op_prefix = cmd_op_prefix;
    fifo_din.op        = cmd_op;
  end

  alu_cmd_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clk     (clk),
    .reset_n (reset_n),
    .push    (fifo_push),
    .din     (fifo_din),
    .pop     (fifo_pop),
    .dout    (fifo_dout),
    .full    (fifo_full),
    .empty   (fifo_empty),
    .count   (count)
  );

  // Issuer FSM: pop and issue, hold start until done, hold response until taken
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q      <= IDLE;
      start_q      <= 1'b0;
      op_q         <= '0;
      a_q          <= '0;
      b_q          <= '0;
      sv_q         <= 1'b0;
      op_prefix_q  <= 1'b0;
      rsp_valid_q  <= 1'b0;
      rsp_result_q <= '0;
      rsp_err_q    <= '0;
      rsp_gp_q     <= 1'b0;
`ifdef ISSUER_TIMEOUT_EN
      timer_q        <= '0;
      timeout_seen_q <= 1'b0;
`endif
    end else begin
      unique case (state_q)
        IDLE: begin
          if (!fifo_empty) begin
            a_q         <= fifo_dout.a;
            b_q         <= fifo_dout.b;
            sv_q        <= fifo_dout.sv;
            op_prefix_q <= fifo_dout.op_prefix;
            op_q        <= fifo_dout.op;
            start_q     <= 1'b1;
            state_q     <= ISSUE;
`ifdef ISSUER_TIMEOUT_EN
            timer_q     <= '0;
`endif
          end
        end
        ISSUE: begin
          if (done) begin
            rsp_result_q <= result;
            rsp_err_q    <= err;
            rsp_gp_q     <= gp;
            rsp_valid_q  <= 1'b1;
            start_q      <= 1'b0;
            state_q      <= RESP;
          end
`ifdef ISSUER_TIMEOUT_EN
          else if (timer_q == TW'(TIMEOUT_CYCLES - 1)) begin
            rsp_result_q   <= '0;
            rsp_err_q      <= ERR_TIMEOUT;
            rsp_gp_q       <= 1'b0;
            rsp_valid_q    <= 1'b1;
            start_q        <= 1'b0;
            state_q        <= RESP;
            timeout_seen_q <= 1'b1;
          end else begin
            timer_q <= timer_q + 1'b1;
          end
`endif
        end
        RESP: begin
          if (rsp_ready) begin
            rsp_valid_q <= 1'b0;
            state_q     <= IDLE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign start      = start_q;
  assign op         = op_q;
  assign A          = a_q;
  assign B          = b_q;
  assign sv         = sv_q;
  assign op_prefix  = op_prefix_q;
  assign rsp_valid  = rsp_valid_q;
  assign rsp_result = rsp_result_q;
  assign rsp_err    = rsp_err_q;
  assign rsp_gp     = rsp_gp_q;

endmodule

// File: tb/tb_alu_cmd_issuer.sv
// Directed bench for alu_cmd_issuer with a behavioural ALU responder and a
// response scoreboard. Build with ISSUER_TIMEOUT_EN to add the watchdog test.
module tb_alu_cmd_issuer;

  logic        clk;
  logic        reset_n;
  logic        cmd_valid;
  logic        cmd_ready;
  logic [31:0] cmd_a;
  logic [31:0] cmd_b;
  logic        cmd_sv;
  logic        cmd_op_prefix;
  logic [7:0]  cmd_op;
  logic        start;
  logic [7:0]  op;
  logic [31:0] A;
  logic [31:0] B;
  logic        sv;
  logic        op_prefix;
  logic        done;
  logic [63:0] result;
  logic [7:0]  err;
  logic        gp;
  logic        rsp_valid;
  logic        rsp_ready;
  logic [63:0] rsp_result;
  logic [7:0]  rsp_err;
  logic        rsp_gp;
  logic        busy;
  logic [2:0]  count;
`ifdef ISSUER_TIMEOUT_EN
  logic        timeout_seen;
`endif

  int checks   = 0;
  int failures = 0;
  int rsp_count = 0;
  logic [72:0] sb[$];

  bit alu_auto = 0;
  int alu_lat  = 1;
  int alu_cnt  = 0;

  alu_cmd_issuer #(
    .DEPTH(4)
`ifdef ISSUER_TIMEOUT_EN
    , .TIMEOUT_CYCLES(8)
`endif
  ) dut (
    .clk(clk), .reset_n(reset_n),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_a(cmd_a), .cmd_b(cmd_b), .cmd_sv(cmd_sv),
    .cmd_op_prefix(cmd_op_prefix), .cmd_op(cmd_op),
    .start(start), .op(op), .A(A), .B(B), .sv(sv), .op_prefix(op_prefix),
    .done(done), .result(result), .err(err), .gp(gp),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
    .rsp_result(rsp_result), .rsp_err(rsp_err), .rsp_gp(rsp_gp),
    .busy(busy), .count(count)
`ifdef ISSUER_TIMEOUT_EN
    , .timeout_seen(timeout_seen)
`endif
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Reference ALU behaviour: {result, err, gp}
  function automatic logic [72:0] alu_model(input logic [31:0] a, input logic [31:0] b,
                                            input logic [7:0] o, input logic s, input logic p);
    logic [63:0] r;
    if (o == 8'd1) r = {32'b0, a} + {32'b0, b};
    else           r = {a ^ {24'b0, o}, b + 32'd3};
    return {r, o ^ 8'h01, s ^ p};
  endfunction

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  // Called at a negedge; returns at the negedge after acceptance
  task automatic push_cmd(input logic [31:0] a, input logic [31:0] b, input logic [7:0] o,
                          input logic s, input logic p, input int max_wait, output bit ok);
    cmd_valid = 1'b1; cmd_a = a; cmd_b = b; cmd_op = o; cmd_sv = s; cmd_op_prefix = p;
    ok = 1'b0;
    for (int i = 0; i < max_wait && !ok; i++) begin
      if (cmd_ready) begin
        ok = 1'b1;
        sb.push_back(alu_model(a, b, o, s, p));
      end
      @(negedge clk);
    end
    cmd_valid = 1'b0;
  endtask

  task automatic wait_idle(input string tag);
    bit ok = 1'b0;
    for (int i = 0; i < 300 && !ok; i++) begin
      @(negedge clk);
      ok = (sb.size() == 0) && !busy && !rsp_valid;
    end
    chk(tag, ok, 1'b1);
  endtask

  task automatic wait_start(input string tag);
    bit ok = 1'b0;
    for (int i = 0; i < 50 && !ok; i++) begin
      @(negedge clk);
      ok = start;
    end
    chk(tag, ok, 1'b1);
  endtask

  // ALU responder: raises done for one cycle alu_lat negedges into a command
  always @(negedge clk) begin
    if (alu_auto && start && reset_n) begin
      if (alu_cnt == alu_lat - 1) begin
        {result, err, gp} = alu_model(A, B, op, sv, op_prefix);
        done = 1'b1;
        alu_cnt = 0;
      end else begin
        done = 1'b0;
        alu_cnt++;
      end
    end else begin
      done = 1'b0;
      alu_cnt = 0;
    end
  end

  // Response scoreboard: compare each accepted response against the queue
  always @(negedge clk) begin
    logic [72:0] exp;
    #2;
    if (reset_n && rsp_valid && rsp_ready) begin
      chk("sb_nonempty", (sb.size() > 0), 1'b1);
      if (sb.size() > 0) begin
        exp = sb.pop_front();
        chk("rsp_result", rsp_result, exp[72:9]);
        chk("rsp_err", {56'b0, rsp_err}, {56'b0, exp[8:1]});
        chk("rsp_gp", rsp_gp, exp[0]);
        rsp_count++;
        $display("rsp #%0d result=0x%0h err=0x%0h gp=%0b", rsp_count, rsp_result, rsp_err, rsp_gp);
      end
    end
  end

  // Bus monitor: start gap between commands and bus stability while start is high
  logic        prev_start = 1'b0;
  logic [73:0] prev_bus   = '0;
  int          low_cnt    = 0;
  bit          seen_first = 1'b0;
  always @(negedge clk) begin
    if (!reset_n) begin
      seen_first = 1'b0;
      low_cnt    = 0;
      prev_start = 1'b0;
    end else begin
      if (start && !prev_start) begin
        if (seen_first) chk("start_gap", (low_cnt >= 2), 1'b1);
        seen_first = 1'b1;
        low_cnt    = 0;
      end else if (!start) begin
        low_cnt++;
      end
      if (start && prev_start) chk("bus_stable", ({A, B, sv, op_prefix, op} === prev_bus), 1'b1);
      prev_start = start;
      prev_bus   = {A, B, sv, op_prefix, op};
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    bit          ok;
    int          n;
    int          rsp0;
    logic [63:0] r_snap;
    logic [7:0]  e_snap;
    logic        g_snap;

    reset_n = 1'b0; cmd_valid = 1'b0; cmd_a = '0; cmd_b = '0; cmd_sv = 1'b0;
    cmd_op_prefix = 1'b0; cmd_op = '0; rsp_ready = 1'b0;
    done = 1'b0; result = '0; err = '0; gp = 1'b0;

    // Reset state
    #3;
    chk("rst_start", start, 1'b0);
    chk("rst_rsp_valid", rsp_valid, 1'b0);
    chk("rst_count", count, 3'd0);
    chk("rst_cmd_ready", cmd_ready, 1'b0);
    chk("rst_busy", busy, 1'b0);
    chk("rst_bus", {A, B, op}, '0);
    repeat (2) @(negedge clk);
    reset_n = 1'b1;
    @(negedge clk);
    chk("idle_cmd_ready", cmd_ready, 1'b1);

    // Single command: 5 + 7 with a 3-cycle ALU
    rsp_ready = 1'b1; alu_auto = 1'b1; alu_lat = 3;
    push_cmd(32'd5, 32'd7, 8'd1, 1'b0, 1'b0, 5, ok);
    chk("t1_accept", ok, 1'b1);
    chk("t1_start_not_yet", start, 1'b0);
    chk("t1_count", count, 3'd1);
    @(negedge clk);
    chk("t1_start", start, 1'b1);
    chk("t1_bus", {A, B, op}, {32'd5, 32'd7, 8'd1});
    n = 1;
    for (int i = 0; i < 50 && start; i++) begin
      @(negedge clk);
      if (start) n++;
    end
    chk("t1_start_cycles", n, 3);
    chk("t1_rsp_valid", rsp_valid, 1'b1);
    chk("t1_rsp_result", rsp_result, 64'd12);
    chk("t1_rsp_err", rsp_err, 8'd0);
    wait_idle("t1_drain");

    // Back-to-back: four commands with no gap
    rsp0 = rsp_count; alu_lat = 2;
    for (int i = 0; i < 4; i++) begin
      push_cmd(32'(i * 3 + 1), 32'(i * 100), 8'(2 + i), i[0], i[1], 20, ok);
      chk("t2_accept", ok, 1'b1);
    end
    wait_idle("t2_drain");
    chk("t2_rsp_count", rsp_count - rsp0, 4);

    // Full FIFO: ALU silent, one issued plus four buffered
    alu_auto = 1'b0;
    for (int i = 0; i < 5; i++) begin
      push_cmd(32'hA000_0000 + 32'(i), 32'(i), 8'h80 + 8'(i), 1'b1, 1'b0, 1, ok);
      chk("t3_accept", ok, 1'b1);
    end
    chk("t3_count", count, 3'd4);
    chk("t3_cmd_ready", cmd_ready, 1'b0);
    chk("t3_busy", busy, 1'b1);
    chk("t3_start", start, 1'b1);
    push_cmd(32'hDEAD, 32'hBEEF, 8'd3, 1'b0, 1'b0, 1, ok);
    chk("t3_sixth_refused", ok, 1'b0);
    alu_auto = 1'b1; alu_lat = 1;
    wait_idle("t3_drain");
    chk("t3_count_empty", count, 3'd0);

    // Response backpressure
    alu_lat = 2; rsp_ready = 1'b0;
    push_cmd(32'h1234, 32'h5678, 8'd1, 1'b1, 1'b1, 20, ok);
    push_cmd(32'h0F0F, 32'h00FF, 8'd7, 1'b0, 1'b1, 20, ok);
    ok = 1'b0;
    for (int i = 0; i < 50 && !ok; i++) begin
      @(negedge clk);
      ok = rsp_valid;
    end
    chk("t4_rsp_valid", ok, 1'b1);
    r_snap = rsp_result; e_snap = rsp_err; g_snap = rsp_gp;
    chk("t4_first_result", r_snap, 64'h1234 + 64'h5678);
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      chk("t4_hold_valid", rsp_valid, 1'b1);
      chk("t4_hold_rsp", {rsp_result, rsp_err, rsp_gp}, {r_snap, e_snap, g_snap});
      chk("t4_no_start", start, 1'b0);
    end
    rsp_ready = 1'b1;
    wait_start("t4_next_start");
    chk("t4_next_bus", {A, B, op}, {32'h0F0F, 32'h00FF, 8'd7});
    wait_idle("t4_drain");

    // Reset while a command is in flight with two queued
    alu_auto = 1'b0;
    for (int i = 0; i < 3; i++) push_cmd(32'(i), 32'(i), 8'd2, 1'b0, 1'b0, 20, ok);
    chk("t5_start_before", start, 1'b1);
    chk("t5_count_before", count, 3'd2);
    #2 reset_n = 1'b0;
    #1;
    chk("t5_async_start", start, 1'b0);
    chk("t5_async_count", count, 3'd0);
    chk("t5_async_rsp", rsp_valid, 1'b0);
    chk("t5_async_busy", busy, 1'b0);
    sb.delete();
    repeat (2) @(negedge clk);
    reset_n = 1'b1;
    alu_auto = 1'b1;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      chk("t5_quiet", {start, rsp_valid}, 2'b00);
    end

`ifdef ISSUER_TIMEOUT_EN
    // Watchdog: ALU never answers
    alu_auto = 1'b0; rsp_ready = 1'b0;
    chk("t6_seen_clear", timeout_seen, 1'b0);
    push_cmd(32'h11, 32'h22, 8'd4, 1'b0, 1'b0, 5, ok);
    wait_start("t6_start");
    n = 1;
    for (int i = 0; i < 100 && start; i++) begin
      @(negedge clk);
      if (start) n++;
    end
    chk("t6_issue_cycles", n, 8);
    chk("t6_rsp_valid", rsp_valid, 1'b1);
    chk("t6_rsp_err", rsp_err, 8'hFF);
    chk("t6_rsp_result", rsp_result, 64'd0);
    chk("t6_timeout_seen", timeout_seen, 1'b1);
    void'(sb.pop_front());
    sb.push_back({64'd0, 8'hFF, 1'b0});
    rsp_ready = 1'b1;
    wait_idle("t6_drain");
    chk("t6_seen_sticky", timeout_seen, 1'b1);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
